// File: rtl/user_io_ctrl.sv
// Board user-I/O controller: debounced buttons/DIPs with rise/fall interrupt
// pending, per-LED PWM dimming, and a small word-addressed register port.
module user_io_ctrl #(
  parameter int              N_IN            = 6,
  parameter int              N_LED           = 8,
  parameter int              DEBOUNCE_CYCLES = 240000,
  parameter int              PWM_BITS        = 8,
  parameter logic [N_IN-1:0] INV_MASK        = 6'b000011
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_IN-1:0]  PIN_IN,
  output logic [N_LED-1:0] LED_OUT,
  input  logic [3:0]       REG_ADDR,
  input  logic             REG_WR,
  input  logic [31:0]      REG_WDATA,
  input  logic             REG_RD,
  output logic [31:0]      REG_RDATA,
  output logic             REG_RVALID,
  output logic             IRQ
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [N_IN-1:0]     sync1, sync2, deb;
  logic [N_IN-1:0]     accept, rise_ev, fall_ev;
  logic [CW-1:0]       db_cnt [N_IN];
  logic [N_IN-1:0]     pend_rise, pend_fall, mask_rise, mask_fall;
  logic [N_IN-1:0]     w1c_rise, w1c_fall;
  logic [PWM_BITS-1:0] duty   [N_LED];
  logic [PWM_BITS-1:0] shadow [N_LED];
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                pwm_wrap;
  logic                pend_wr, mask_wr, duty_sel;
  logic [2:0]          duty_idx;
  logic [31:0]         rd_mux;
  logic                unused_wdata;

  assign unused_wdata = ^REG_WDATA;

  // A level is accepted on the cycle its disagreement has lasted DEBOUNCE_CYCLES.
  always_comb begin
    accept = '0;
    for (int i = 0; i < N_IN; i++)
      accept[i] = (sync2[i] != deb[i]) && (db_cnt[i] == DB_MAX);
  end

  assign rise_ev = accept & sync2;
  assign fall_ev = accept & ~sync2;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      for (int i = 0; i < N_IN; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= PIN_IN ^ INV_MASK;
      sync2 <= sync1;
      deb   <= deb ^ accept;
      for (int i = 0; i < N_IN; i++) begin
        if ((sync2[i] == deb[i]) || accept[i]) db_cnt[i] <= '0;
        else                                    db_cnt[i] <= db_cnt[i] + CW'(1);
      end
    end
  end

  assign pend_wr  = REG_WR && (REG_ADDR == 4'd1);
  assign mask_wr  = REG_WR && (REG_ADDR == 4'd2);
  assign duty_sel = REG_ADDR[3] && ({1'b0, REG_ADDR[2:0]} < 4'(N_LED));
  assign duty_idx = REG_ADDR[2:0];
  assign w1c_rise = {N_IN{pend_wr}} & REG_WDATA[N_IN-1:0];
  assign w1c_fall = {N_IN{pend_wr}} & REG_WDATA[16 +: N_IN];

  // Hardware events are OR-ed in after the clear, so a coincident set survives.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pend_rise <= '0;
      pend_fall <= '0;
      mask_rise <= '0;
      mask_fall <= '0;
      IRQ       <= 1'b0;
    end else begin
      pend_rise <= (pend_rise & ~w1c_rise) | rise_ev;
      pend_fall <= (pend_fall & ~w1c_fall) | fall_ev;
      if (mask_wr) begin
        mask_rise <= REG_WDATA[N_IN-1:0];
        mask_fall <= REG_WDATA[16 +: N_IN];
      end
      IRQ <= |((pend_rise & mask_rise) | (pend_fall & mask_fall));
    end
  end

  assign pwm_wrap = &pwm_cnt;

  // Shadow duty reloads only on the last count so a period is never cut short.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pwm_cnt <= '0;
      LED_OUT <= '0;
      for (int k = 0; k < N_LED; k++) begin
        duty[k]   <= '0;
        shadow[k] <= '0;
      end
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      for (int k = 0; k < N_LED; k++) begin
        LED_OUT[k] <= (&shadow[k]) || (pwm_cnt < shadow[k]);
        if (pwm_wrap) shadow[k] <= duty[k];
      end
      if (REG_WR && duty_sel) duty[duty_idx] <= REG_WDATA[PWM_BITS-1:0];
    end
  end

  always_comb begin
    rd_mux = '0;
    case (REG_ADDR)
      4'd0:    rd_mux = 32'(deb);
      4'd1:    rd_mux = {16'(pend_fall), 16'(pend_rise)};
      4'd2:    rd_mux = {16'(mask_fall), 16'(mask_rise)};
      default: if (duty_sel) rd_mux = 32'(duty[duty_idx]);
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      REG_RDATA  <= '0;
      REG_RVALID <= 1'b0;
    end else begin
      REG_RDATA  <= REG_RD ? rd_mux : '0;
      REG_RVALID <= REG_RD;
    end
  end

endmodule

// File: tb/tb_user_io_ctrl.sv
// Directed bench for user_io_ctrl: reads are scored through an expectation
// queue, pin/LED/IRQ behaviour is checked inline against hand-derived values.
module tb_user_io_ctrl;

  localparam int         N_IN  = 6;
  localparam int         N_LED = 8;
  localparam int         DB    = 4;
  localparam int         PB    = 4;
  localparam logic [5:0] INV   = 6'b000001;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic [N_IN-1:0]   PIN_IN = '0;
  logic [N_LED-1:0]  LED_OUT;
  logic [3:0]        REG_ADDR = '0;
  logic              REG_WR = 1'b0;
  logic [31:0]       REG_WDATA = '0;
  logic              REG_RD = 1'b0;
  logic [31:0]       REG_RDATA;
  logic              REG_RVALID;
  logic              IRQ;

  user_io_ctrl #(
    .N_IN(N_IN), .N_LED(N_LED), .DEBOUNCE_CYCLES(DB), .PWM_BITS(PB), .INV_MASK(INV)
  ) dut (
    .CLK(CLK), .RST(RST), .PIN_IN(PIN_IN), .LED_OUT(LED_OUT),
    .REG_ADDR(REG_ADDR), .REG_WR(REG_WR), .REG_WDATA(REG_WDATA),
    .REG_RD(REG_RD), .REG_RDATA(REG_RDATA), .REG_RVALID(REG_RVALID), .IRQ(IRQ)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } rd_t;

  rd_t  sb[$];
  rd_t  mon_e;
  int   n_checks = 0;
  int   n_pass = 0;
  logic rd_d = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] e, input string tag);
    rd_t item;
    item.tag = tag;
    item.exp = e;
    REG_RD   = 1'b1;
    REG_ADDR = a;
    sb.push_back(item);
    @(negedge CLK);
    REG_RD = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    REG_WR    = 1'b1;
    REG_ADDR  = a;
    REG_WDATA = d;
    @(negedge CLK);
    REG_WR = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic count_led0(input int n, output int hits);
    hits = 0;
    for (int k = 0; k < n; k++) begin
      if (LED_OUT[0]) hits++;
      @(negedge CLK);
    end
  endtask

  // Expected read-valid timing: one cycle after a read strobe, never across reset.
  always @(posedge CLK) rd_d <= RST ? 1'b0 : REG_RD;

  always @(negedge CLK) begin
    if (REG_RVALID || rd_d) begin
      chk("rvalid_timing", 32'(REG_RVALID), 32'(rd_d));
      if (REG_RVALID) begin
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk(mon_e.tag, REG_RDATA, mon_e.exp);
        end
      end
    end
  end

  initial begin
    int  hits, ca, cb;
    logic prev, found;

    PIN_IN = N_IN'($urandom);
    repeat (3) @(negedge CLK);
    chk("rst_led",    32'(LED_OUT), 32'd0);
    chk("rst_irq",    32'(IRQ), 32'd0);
    chk("rst_rvalid", 32'(REG_RVALID), 32'd0);
    chk("rst_rdata",  REG_RDATA, 32'd0);
    RST    = 1'b0;
    PIN_IN = 6'b000001;
    rd(4'd0, 32'd0, "rst_status");
    idle(8);

    // 3-cycle glitch on pin 2 must be rejected
    PIN_IN[2] = 1'b1; idle(3); PIN_IN[2] = 1'b0; idle(10);
    rd(4'd1, 32'd0, "glitch_pend");
    rd(4'd0, 32'd0, "glitch_status");

    // sustained level: accepted exactly DB+2 cycles after the pin edge
    PIN_IN[2] = 1'b1; idle(5);
    rd(4'd0, 32'd0, "db_status_5");
    rd(4'd0, 32'h4, "db_status_6");
    rd(4'd1, 32'h4, "db_pend_rise");
    idle(2);
    PIN_IN[2] = 1'b0; idle(10);
    rd(4'd1, 32'h0004_0004, "db_pend_both");
    rd(4'd0, 32'd0, "db_status_low");
    wr(4'd1, 32'hFFFF_FFFF);
    rd(4'd1, 32'd0, "pend_cleared");

    // active-low button on pin 0
    PIN_IN[0] = 1'b0; idle(10);
    rd(4'd0, 32'h1, "btn_status");
    rd(4'd1, 32'h1, "btn_pend_rise");
    PIN_IN[0] = 1'b1; idle(10);
    rd(4'd1, 32'h0001_0001, "btn_pend_both");
    rd(4'd0, 32'd0, "btn_status_rel");

    chk("irq_unmasked_off", 32'(IRQ), 32'd0);
    wr(4'd2, 32'h1);
    chk("irq_pre", 32'(IRQ), 32'd0);
    @(negedge CLK);
    chk("irq_set", 32'(IRQ), 32'd1);
    rd(4'd2, 32'h1, "mask_rb");
    wr(4'd1, 32'h1);
    chk("irq_hold", 32'(IRQ), 32'd1);
    @(negedge CLK);
    chk("irq_clr", 32'(IRQ), 32'd0);
    rd(4'd1, 32'h0001_0000, "pend_after_w1c");

    PIN_IN[0] = 1'b0; idle(8);
    chk("irq_rearm", 32'(IRQ), 32'd1);
    PIN_IN[0] = 1'b1; idle(10);
    // clear lands on the same edge as a new rise: set must win
    PIN_IN[0] = 1'b0; idle(5);
    wr(4'd1, 32'h1);
    chk("irq_setwins0", 32'(IRQ), 32'd1);
    @(negedge CLK);
    chk("irq_setwins1", 32'(IRQ), 32'd1);
    rd(4'd1, 32'h0001_0001, "pend_setwins");

    wr(4'd8, 32'd4); idle(20);
    count_led0(32, hits);
    chk("pwm_duty4", 32'(hits), 32'd8);
    chk("led_others", 32'(LED_OUT[7:1]), 32'd0);
    wr(4'd8, 32'd15); idle(20);
    count_led0(16, hits);
    chk("pwm_full", 32'(hits), 32'd16);
    wr(4'd8, 32'd0); idle(20);
    count_led0(16, hits);
    chk("pwm_zero", 32'(hits), 32'd0);

    // align to period start, then change duty mid-period
    wr(4'd8, 32'd4); idle(20);
    prev  = LED_OUT[0];
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge CLK);
      if (!prev && LED_OUT[0]) found = 1'b1;
      prev = LED_OUT[0];
    end
    chk("pwm_sync_found", 32'(found), 32'd1);
    ca = 0; cb = 0;
    for (int k = 0; k < 32; k++) begin
      if (LED_OUT[0]) begin
        if (k < 16) ca++;
        else        cb++;
      end
      if (k == 2) begin
        REG_WR = 1'b1; REG_ADDR = 4'd8; REG_WDATA = 32'd12;
      end
      if (k == 3) REG_WR = 1'b0;
      @(negedge CLK);
    end
    chk("pwm_old_duty", 32'(ca), 32'd4);
    chk("pwm_new_duty", 32'(cb), 32'd12);

    rd(4'd5, 32'd0, "addr5");
    wr(4'd5, 32'hFFFF_FFFF);
    rd(4'd5, 32'd0, "addr5_after_wr");
    wr(4'd11, 32'h0000_00AB);
    rd(4'd11, 32'h0000_00AB & ((32'd1 << PB) - 32'd1), "duty3_rb");
    rd(4'd15, 32'd0, "addr15");
    rd(4'd8, 32'd12, "duty0_rb");

    begin
      rd_t item;
      item.tag = "rw_same_pre";
      item.exp = 32'h1;
      REG_RD = 1'b1; REG_WR = 1'b1; REG_ADDR = 4'd2; REG_WDATA = 32'h3;
      sb.push_back(item);
      @(negedge CLK);
      REG_RD = 1'b0; REG_WR = 1'b0;
    end
    rd(4'd2, 32'h3, "rw_same_post");

    // reset with a read in flight
    chk("pre_rst_irq", 32'(IRQ), 32'd1);
    RST = 1'b1; REG_RD = 1'b1; REG_ADDR = 4'd0;
    @(negedge CLK);
    RST = 1'b0; REG_RD = 1'b0;
    chk("midrst_rvalid", 32'(REG_RVALID), 32'd0);
    chk("midrst_irq",    32'(IRQ), 32'd0);
    chk("midrst_led",    32'(LED_OUT), 32'd0);
    rd(4'd0, 32'd0, "post_rst_status");
    idle(10);
    rd(4'd1, 32'h1, "post_rst_rise");
    rd(4'd2, 32'd0, "post_rst_mask");
    rd(4'd8, 32'd0, "post_rst_duty");

    idle(3);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
